// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation core among N requesters.
// Optional grant locking is enabled by defining ASCON_ARB_LOCK_EN.
module ascon_perm_arbiter #(
    parameter int N    = 2,
    parameter int MAXR = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [320*N-1:0]   req_state,
    input  logic [5*N-1:0]     req_rounds,
    input  logic [N-1:0]       req_lock,
    output logic [N-1:0]       resp_valid,
    output logic [319:0]       resp_state,
    output logic               busy,
    output logic [319:0]       perm_S,
    output logic [4:0]         perm_rounds,
    output logic               perm_start,
    input  logic [319:0]       perm_out,
    input  logic               perm_done
);
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    r_state;
    logic [GW-1:0] r_last;
    logic [GW-1:0] r_g;
    logic [319:0]  r_S;
    logic [4:0]    r_rd;
    logic [319:0]  r_resp;

    logic [GW-1:0] w_g;
    logic [GW-1:0] w_j;
    logic [319:0]  w_st;
    logic [4:0]    w_rd;
    logic          w_acc;
    logic          w_byp;
    logic [N-1:0]  w_one;

`ifdef ASCON_ARB_LOCK_EN
    logic r_lk;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
`endif

    // Highest k wins first, so the last write is the nearest requester after r_last
    always_comb begin
        w_g = r_last;
        w_j = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = GW'((int'(r_last) + k) % N);
            if (req_valid[w_j]) w_g = w_j;
        end
`ifdef ASCON_ARB_LOCK_EN
        if (r_lk && req_valid[r_g]) w_g = r_g;
`endif
    end

    always_comb begin
        w_st = '0;
        w_rd = '0;
        for (int i = 0; i < N; i++) begin
            if (w_g == GW'(i)) begin
                w_st = req_state[320*i +: 320];
                w_rd = req_rounds[5*i +: 5];
            end
        end
    end

    assign w_one = {{(N-1){1'b0}}, 1'b1};
    assign w_acc = (r_state == S_IDLE) && (|req_valid);
    assign w_byp = (w_rd == 5'd0) || (w_rd > 5'(MAXR));

    assign req_ready   = (w_acc && rst) ? (w_one << w_g) : '0;
    assign resp_valid  = (r_state == S_RESP) ? (w_one << r_g) : '0;
    assign busy        = (r_state != S_IDLE);
    assign perm_start  = (r_state == S_BUSY) && !perm_done;
    assign perm_S      = r_S;
    assign perm_rounds = r_rd;
    assign resp_state  = r_resp;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_last  <= GW'(N - 1);
            r_g     <= '0;
            r_S     <= '0;
            r_rd    <= '0;
            r_resp  <= '0;
`ifdef ASCON_ARB_LOCK_EN
            r_lk    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_g  <= w_g;
                        r_S  <= w_st;
                        r_rd <= w_rd;
                        if (w_byp) begin
                            r_resp  <= w_st;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (perm_done) begin
                        r_resp  <= perm_out;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
`ifdef ASCON_ARB_LOCK_EN
                    // A locked winner keeps the pointer so it is re-granted next
                    if (req_lock[r_g]) begin
                        r_lk <= 1'b1;
                    end else begin
                        r_lk   <= 1'b0;
                        r_last <= r_g;
                    end
`else
                    r_last <= r_g;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Scoreboard bench for ascon_perm_arbiter with a stand-in permutation core.
// Lock scenarios run only when ASCON_ARB_LOCK_EN is defined.
module tb_ascon_perm_arbiter;
    localparam int N    = 2;
    localparam int MAXR = 12;
    localparam int W    = 320 * N;
`ifdef ASCON_ARB_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [W-1:0]   req_state;
    logic [5*N-1:0] req_rounds;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   resp_valid;
    logic [319:0]   resp_state;
    logic           busy;
    logic [319:0]   perm_S;
    logic [4:0]     perm_rounds;
    logic           perm_start;
    logic [319:0]   perm_out;
    logic           perm_done;

    always #5 clk = ~clk;

    ascon_perm_arbiter #(.N(N), .MAXR(MAXR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_rounds(req_rounds),
        .req_lock(req_lock),
        .resp_valid(resp_valid), .resp_state(resp_state),
        .busy(busy),
        .perm_S(perm_S), .perm_rounds(perm_rounds),
        .perm_start(perm_start),
        .perm_out(perm_out), .perm_done(perm_done)
    );

    typedef struct {
        int           id;
        logic [319:0] st;
    } exp_t;

    exp_t sb[$];
    int   chk = 0;
    int   err = 0;
    int   cyc = 0;

    // reference arbitration state
    int m_last = N - 1;
    bit m_lk   = 1'b0;
    int m_lkg  = 0;

    // monitor bookkeeping
    bit           pend_v = 1'b0;
    int           pend_g = 0;
    bit           pend_byp = 1'b0;
    logic [319:0] pend_st;
    logic [4:0]   pend_rd;
    int           acc_cyc = 0;
    int           done_cyc = -10;
    bit           first_chk = 1'b0;
    int           ngrant = 0;
    int           g0_run = 0;
    int           g0_max = 0;
    int           g1_cnt = 0;

    // core model controls
    int cnt = 0;
    int lat_lo = 1;
    int lat_hi = 4;
    bit spur = 1'b0;
    bit lock_rand = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic ck(input bit ok, input string nm,
                      input logic [319:0] act, input logic [319:0] exp);
        chk++;
        if (!ok) begin
            err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [319:0] core_f(input logic [319:0] s,
                                            input logic [4:0] r);
        return {s[318:0], s[319]} ^ {64{r}};
    endfunction

    function automatic bit bitof(input logic [N-1:0] v, input int j);
        logic [N-1:0] t;
        t = v >> j;
        return t[0];
    endfunction

    function automatic logic [319:0] st_of(input logic [W-1:0] v, input int i);
        logic [W-1:0] t;
        t = v >> (320 * i);
        return t[319:0];
    endfunction

    function automatic logic [4:0] rd_of(input logic [5*N-1:0] v, input int i);
        logic [5*N-1:0] t;
        t = v >> (5 * i);
        return t[4:0];
    endfunction

    // Round-robin rule: locked owner first, else first requester after the last winner
    function automatic int m_grant(input logic [N-1:0] v);
        if (LK && m_lk && bitof(v, m_lkg)) return m_lkg;
        for (int k = 1; k <= N; k++) begin
            if (bitof(v, (m_last + k) % N)) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [319:0] rnd320();
        logic [319:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
        return r;
    endfunction

    function automatic logic [4:0] rnd_rd();
        case ($urandom_range(3, 0))
            0:       return 5'd0;
            1:       return 5'($urandom_range(31, 13));
            default: return 5'($urandom_range(12, 1));
        endcase
    endfunction

    task automatic issue(input int i, input logic [319:0] st, input logic [4:0] rd);
        exp_t e;
        logic [W-1:0]   m;
        logic [5*N-1:0] mr;
        m  = W'({320{1'b1}}) << (320 * i);
        mr = (5*N)'(5'h1f) << (5 * i);
        req_state  = (req_state & ~m) | (W'(st) << (320 * i));
        req_rounds = (req_rounds & ~mr) | ((5*N)'(rd) << (5 * i));
        req_valid  = req_valid | (N'(1) << i);
        e.id = i;
        e.st = (rd >= 5'd1 && rd <= 5'(MAXR)) ? core_f(st, rd) : st;
        sb.push_back(e);
    endtask

    task automatic step(input int prob);
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (spur) begin
            perm_done = 1'b1;
        end else if (perm_done) begin
            perm_done = 1'b0;
            perm_out  = rnd320();
        end else if (perm_start) begin
            if (cnt == 0) cnt = int'($urandom_range(lat_hi, lat_lo));
            cnt--;
            if (cnt == 0) begin
                perm_done = 1'b1;
                perm_out  = core_f(perm_S, perm_rounds);
            end else begin
                perm_out = rnd320();
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bitof(acc, i)) req_valid = req_valid & ~(N'(1) << i);
            if (!bitof(req_valid, i) && int'($urandom_range(99, 0)) < prob)
                issue(i, rnd320(), rnd_rd());
        end
        if (lock_rand) req_lock = N'($urandom());
    endtask

    task automatic wait_drain(input int bound, input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || req_valid != '0) && n < bound) begin
            step(0);
            n++;
        end
        ck(n < bound, {nm, "_drain"}, n, bound);
    endtask

    // Monitor: checks grants, core handoff and responses against the model
    int eg;
    int idx;
    always @(negedge clk) begin
        if (rst) begin
            if (req_ready != '0) begin
                eg = m_grant(req_valid);
                ck(!pend_v && eg >= 0 && req_ready == (N'(1) << eg),
                   "grant", req_ready, N'(1) << eg);
                if (first_chk) begin
                    ck(req_ready == N'(1), "first_after_reset", req_ready, 1);
                    first_chk = 1'b0;
                end
                if (eg >= 0) begin
                    pend_g   = eg;
                    pend_st  = st_of(req_state, eg);
                    pend_rd  = rd_of(req_rounds, eg);
                    pend_byp = (pend_rd == 5'd0) || (pend_rd > 5'(MAXR));
                    pend_v   = 1'b1;
                    acc_cyc  = cyc;
                    ngrant++;
                    if (eg == 0) begin
                        g0_run++;
                        if (g0_run > g0_max) g0_max = g0_run;
                    end else begin
                        g0_run = 0;
                    end
                    if (eg == 1) g1_cnt++;
                end
            end else if (!busy) begin
                ck(req_valid == '0, "idle_no_accept", req_valid, 0);
            end
            if (busy) begin
                ck(perm_start == (pend_v && !pend_byp && resp_valid == '0 && !perm_done),
                   "perm_start", perm_start, !perm_start);
            end
            if (perm_start) begin
                ck(perm_S == pend_st && perm_rounds == pend_rd, "core_in", perm_S, pend_st);
            end
            if (busy && perm_done && resp_valid == '0) done_cyc = cyc;
            if (resp_valid != '0) begin
                ck(pend_v && resp_valid == (N'(1) << pend_g), "resp_onehot",
                   resp_valid, N'(1) << pend_g);
                ck(cyc == (pend_byp ? acc_cyc + 1 : done_cyc + 1), "latency",
                   cyc, pend_byp ? acc_cyc + 1 : done_cyc + 1);
                idx = -1;
                for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].id == pend_g) idx = k;
                ck(idx >= 0, "sb_entry", pend_g, idx);
                if (idx >= 0) begin
                    ck(resp_state == sb[idx].st, "resp_state", resp_state, sb[idx].st);
                    sb.delete(idx);
                end
                if (LK && bitof(req_lock, pend_g)) begin
                    m_lk  = 1'b1;
                    m_lkg = pend_g;
                end else begin
                    m_lk   = 1'b0;
                    m_last = pend_g;
                end
                pend_v = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int g_before;
        req_valid  = '0;
        req_state  = '0;
        req_rounds = '0;
        req_lock   = '0;
        perm_out   = '0;
        perm_done  = 1'b0;
        rst        = 1'b0;
        repeat (2) @(posedge clk);
        #1 req_valid = '1;
        @(negedge clk);
        ck(req_ready == '0, "rst_ready", req_ready, 0);
        ck(busy == 1'b0, "rst_busy", busy, 0);
        ck(resp_valid == '0, "rst_resp_valid", resp_valid, 0);
        ck(perm_start == 1'b0, "rst_perm_start", perm_start, 0);
        ck(resp_state == '0, "rst_resp_state", resp_state, 0);
        ck(perm_S == '0 && perm_rounds == '0, "rst_perm_S", perm_S, 0);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b1;

        issue(0, rnd320(), 5'd12);
        wait_drain(50, "single");

        g_before = ngrant;
        repeat (40) step(100);
        ck(ngrant - g_before >= 8, "contention_grants", ngrant - g_before, 8);
        wait_drain(100, "contention");

        issue(0, rnd320(), 5'd0);
        wait_drain(20, "bypass0");
        issue(1, rnd320(), 5'd13);
        wait_drain(20, "bypass13");

        spur = 1'b1;
        repeat (3) step(0);
        spur = 1'b0;
        ck(busy == 1'b0, "spur_busy", busy, 0);
        ck(resp_valid == '0, "spur_resp", resp_valid, 0);
        step(0);
        issue(1, rnd320(), 5'd7);
        wait_drain(30, "after_spur");

        lat_lo = 8;
        lat_hi = 8;
        issue(1, rnd320(), 5'd5);
        n = 0;
        while (!perm_start && n < 20) begin
            step(0);
            n++;
        end
        ck(perm_start == 1'b1, "reach_busy", perm_start, 1);
        step(0);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        perm_done = 1'b0;
        cnt       = 0;
        sb.delete();
        pend_v    = 1'b0;
        m_last    = N - 1;
        m_lk      = 1'b0;
        first_chk = 1'b1;
        lat_lo    = 1;
        lat_hi    = 4;
        ck(busy == 1'b0 && perm_start == 1'b0, "midrst_busy", busy, 0);
        ck(resp_valid == '0, "midrst_resp", resp_valid, 0);
        ck(perm_S == '0 && resp_state == '0, "midrst_data", perm_S, 0);
        issue(0, rnd320(), rnd_rd());
        issue(1, rnd320(), rnd_rd());
        wait_drain(100, "post_reset");

        lock_rand = 1'b1;
        repeat (600) step(35);
        lock_rand = 1'b0;
        req_lock  = '0;
        wait_drain(300, "random");

`ifdef ASCON_ARB_LOCK_EN
        req_lock = N'(1);
        g0_run   = 0;
        g0_max   = 0;
        repeat (30) step(100);
        ck(g0_max >= 3, "lock_streak", g0_max, 3);
        req_lock = '0;
        g_before = g1_cnt;
        repeat (20) step(100);
        ck(g1_cnt > g_before, "lock_release", g1_cnt, g_before + 1);
        wait_drain(100, "lock");
`endif

        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule
